aes_key_schedule_multi: RTL and testbench

Parametrised AES key schedule supporting AES-128/192/256, selected per key load. Expands the cipher key word-serially, one 32-bit word per cycle, into an internal round-key table. Serves the AES/InvAES datapath with a 128-bit round key per round index, in forward or reversed order. Successor to the fixed AES-128 schedule; adds selectable key length, an illegal-request error, a table-valid flag and an optional output register.

---
 rtl/aes_key_schedule_multi.sv | 190 +++++++++++++++++++
 tb/tb_aes_key_schedule_multi.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule_multi.sv
// AES-128/192/256 key schedule: word-serial expansion into a round-key table,
// with forward or reversed 128-bit round-key readout.
module aes_key_schedule_multi #(
  parameter int MAX_KEYLEN = 256,
  parameter bit OUT_REG    = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_init,
  input  logic [1:0]   i_keylen,
  input  logic [255:0] i_key,
  input  logic         i_decrypt,
  input  logic [3:0]   i_round,
  output logic [127:0] o_roundkey,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_valid,
  output logic         o_err,
  output logic [3:0]   o_nr
);

  localparam int NR_MAX = (MAX_KEYLEN >= 256) ? 14 : (MAX_KEYLEN >= 192) ? 12 : 10;
  localparam int DEPTH  = 4 * (NR_MAX + 1);

  typedef enum logic {IDLE, EXPAND} state_t;
  state_t state, state_nxt;

  logic [31:0]  tbl [DEPTH];
  logic [31:0]  win [8];
  logic [5:0]   idx, wlast;
  logic [3:0]   nk, mod_cnt, nk_req, nr_req;
  logic [7:0]   rcon;
  logic         legal, accept, last;
  logic [255:0] load_vec;
  logic [31:0]  far, sub_in, sub_out, tmp, new_w;
  logic [3:0]   k;
  logic [5:0]   base;
  logic [127:0] rk_c;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  always_comb begin
    nk_req = 4'd4;
    nr_req = 4'd10;
    legal  = 1'b0;
    case (i_keylen)
      2'd0: legal = 1'b1;
      2'd1: begin nk_req = 4'd6; nr_req = 4'd12; legal = (MAX_KEYLEN >= 192); end
      2'd2: begin nk_req = 4'd8; nr_req = 4'd14; legal = (MAX_KEYLEN >= 256); end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (i_init && legal) begin
        accept    = 1'b1;
        state_nxt = EXPAND;
      end
      EXPAND: if (idx == wlast) begin
        last      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window holds w[i-8..i-1] with w[i-1] in slot 7, so w[i-Nk] is slot 8-Nk.
  always_comb begin
    case (nk)
      4'd6:    far = win[2];
      4'd8:    far = win[0];
      default: far = win[4];
    endcase
    sub_in  = (mod_cnt == 4'd0) ? {win[7][23:0], win[7][31:24]} : win[7];
    sub_out = sub_word(sub_in);
    if (mod_cnt == 4'd0)                   tmp = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && mod_cnt == 4'd4) tmp = sub_out;
    else                                    tmp = win[7];
    new_w = far ^ tmp;
    case (nk_req)
      4'd6:    load_vec = {64'h0, i_key[255:64]};
      4'd8:    load_vec = i_key;
      default: load_vec = {128'h0, i_key[255:128]};
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= IDLE;
      idx     <= '0;
      wlast   <= '0;
      nk      <= '0;
      mod_cnt <= '0;
      rcon    <= 8'h01;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
      o_valid <= 1'b0;
      o_nr    <= '0;
      for (int p = 0; p < 8; p++) win[p] <= '0;
    end else begin
      state  <= state_nxt;
      o_done <= last;
      o_err  <= (state == IDLE) && i_init && !legal;
      if (accept) begin
        nk      <= nk_req;
        o_nr    <= nr_req;
        wlast   <= {nr_req, 2'b11};
        idx     <= {2'b00, nk_req};
        mod_cnt <= '0;
        rcon    <= 8'h01;
        o_valid <= 1'b0;
        for (int p = 0; p < 8; p++) win[p] <= load_vec[255-32*p -: 32];
      end else if (state == EXPAND) begin
        for (int p = 0; p < 7; p++) win[p] <= win[p+1];
        win[7]  <= new_w;
        idx     <= idx + 6'd1;
        mod_cnt <= (mod_cnt == nk - 4'd1) ? 4'd0 : mod_cnt + 4'd1;
        if (mod_cnt == 4'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        if (last) begin
          o_valid <= 1'b1;
          rcon    <= 8'h01;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int j = 0; j < 8; j++)
        if (j < int'(nk_req)) tbl[j] <= i_key[255-32*j -: 32];
    end else if (state == EXPAND) begin
      tbl[idx] <= new_w;
    end
  end

  assign o_busy = (state == EXPAND);

  always_comb begin
    k    = i_decrypt ? (o_nr - i_round) : i_round;
    base = {k, 2'b00};
    rk_c = '0;
    if (o_valid && !o_busy && (i_round <= o_nr))
      rk_c = {tbl[base], tbl[base + 6'd1], tbl[base + 6'd2], tbl[base + 6'd3]};
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [127:0] rk_q;
      always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) rk_q <= '0;
        else        rk_q <= rk_c;
      end
      assign o_roundkey = rk_q;
    end else begin : g_out_comb
      assign o_roundkey = rk_c;
    end
  endgenerate

endmodule

// File: tb/tb_aes_key_schedule_multi.sv
// Directed bench: FIPS-197 key expansion vectors on a full-size combinational
// instance and an AES-128-only registered-output instance sharing the inputs.
module tb_aes_key_schedule_multi;

  logic         i_clk, i_rst, i_init, i_decrypt;
  logic [1:0]   i_keylen;
  logic [255:0] i_key;
  logic [3:0]   i_round;
  logic [127:0] rk0, rk1;
  logic         busy0, done0, valid0, err0, busy1, done1, valid1, err1;
  logic [3:0]   nr0, nr1;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] R256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  aes_key_schedule_multi #(.MAX_KEYLEN(256), .OUT_REG(1'b0)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_init(i_init), .i_keylen(i_keylen), .i_key(i_key),
    .i_decrypt(i_decrypt), .i_round(i_round), .o_roundkey(rk0), .o_busy(busy0),
    .o_done(done0), .o_valid(valid0), .o_err(err0), .o_nr(nr0));

  aes_key_schedule_multi #(.MAX_KEYLEN(128), .OUT_REG(1'b1)) dut_reg (
    .i_clk(i_clk), .i_rst(i_rst), .i_init(i_init), .i_keylen(i_keylen), .i_key(i_key),
    .i_decrypt(i_decrypt), .i_round(i_round), .o_roundkey(rk1), .o_busy(busy1),
    .o_done(done1), .o_valid(valid1), .o_err(err1), .o_nr(nr1));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start(input logic [1:0] keylen, input logic [255:0] key);
    i_keylen = keylen;
    i_key    = key;
    i_init   = 1'b1;
    tick();
    i_init   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (n < 200 && done0 !== 1'b1) begin
      tick();
      n++;
    end
    check_value(tag, 128'(n), 128'(exp_cycles));
  endtask

  task automatic read_key(input string tag, input logic dec, input logic [3:0] rnd,
                          input logic [127:0] exp);
    i_decrypt = dec;
    i_round   = rnd;
    #1;
    check_value(tag, rk0, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_rst = 1'b0; i_init = 1'b0; i_keylen = 2'd0; i_key = '0; i_decrypt = 1'b0; i_round = 4'd0;
    #23;
    check_value("rst_outs", {busy0, done0, valid0, err0, nr0}, '0);
    check_value("rst_rk", rk0, '0);
    check_value("rst_rk_reg", rk1, '0);
    i_rst = 1'b1;
    tick();

    // AES-128 on both instances
    start(2'd0, KEY128);
    check_value("busy128", {busy0, valid0, rk0}, {1'b1, 1'b0, 128'h0});
    wait_done("done128", 40);
    check_value("done128_reg", {3'b0, done1}, 4'd1);
    check_value("nr128", nr0, 4'd10);
    tick();
    check_value("done_pulse", {busy0, done0, valid0}, 3'b001);
    read_key("r128_0", 1'b0, 4'd0, R128_0);
    read_key("r128_1", 1'b0, 4'd1, R128_1);
    read_key("r128_10", 1'b0, 4'd10, R128_10);
    read_key("r128_dec0", 1'b1, 4'd0, R128_10);
    read_key("r128_11", 1'b0, 4'd11, 128'h0);

    // Registered readout follows i_round one cycle later
    i_decrypt = 1'b0; i_round = 4'd0;
    tick();
    check_value("reg_r0", rk1, R128_0);
    i_round = 4'd10;
    #1;
    check_value("reg_hold", rk1, R128_0);
    tick();
    check_value("reg_r10", rk1, R128_10);

    // Illegal key length leaves the stored schedule alone
    start(2'd3, KEY256);
    check_value("err3", {err0, busy0, err1, busy1}, 4'b1010);
    tick();
    check_value("err3_pulse", {err0, valid0}, 2'b01);
    read_key("err3_keep", 1'b0, 4'd1, R128_1);

    // AES-192; the AES-128-only instance rejects it
    start(2'd1, KEY192);
    check_value("err192_reg", {err1, busy1, err0, busy0}, 4'b1001);
    wait_done("done192", 46);
    check_value("nr192", nr0, 4'd12);
    tick();
    read_key("r192_12", 1'b0, 4'd12, R192_12);
    read_key("r192_13", 1'b0, 4'd13, 128'h0);
    i_round = 4'd10;
    tick();
    check_value("reg_keep128", {nr1, rk1}, {4'd10, R128_10});

    // AES-256 with an init re-asserted while busy
    start(2'd2, KEY256);
    check_value("err256_reg", {3'b0, err1}, 4'd1);
    n = 0;
    while (n < 200 && done0 !== 1'b1) begin
      tick();
      n++;
      if (n == 10) begin
        i_init = 1'b1;
        i_keylen = 2'd3;
      end else if (n == 11) begin
        i_init = 1'b0;
        check_value("busy_init_ign", {err0, busy0}, 2'b01);
      end
    end
    check_value("done256", 128'(n), 128'd52);
    check_value("nr256", nr0, 4'd14);
    tick();
    read_key("r256_0", 1'b0, 4'd0, R256_0);
    read_key("r256_1", 1'b0, 4'd1, R256_1);
    read_key("r256_14", 1'b0, 4'd14, R256_14);
    read_key("r256_dec0", 1'b1, 4'd0, R256_14);

    // Reset in the middle of an expansion
    start(2'd0, KEY128);
    for (int c = 1; c < 20; c++) tick();
    i_rst = 1'b0;
    i_decrypt = 1'b0; i_round = 4'd1;
    #2;
    check_value("midrst_outs", {busy0, done0, valid0, err0, nr0}, '0);
    check_value("midrst_rk", {rk0 | rk1, valid1, busy1}, '0);
    tick();
    i_rst = 1'b1;
    tick();
    read_key("midrst_rk_after", 1'b0, 4'd1, 128'h0);

    start(2'd1, KEY192);
    wait_done("done192_again", 46);
    tick();
    read_key("r192_12_again", 1'b0, 4'd12, R192_12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
